// File: rtl/rf_write_arbiter_if.sv
// Writeback bundle for rf_write_arbiter: two requester ports, issue-stage claim,
// register-file write outputs and the pending-write scoreboard.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic                      a_valid;
    logic [ADDR_W-1:0]         a_reg;
    logic signed [DATA_W-1:0]  a_data;
    logic                      a_ready;

    logic                      b_valid;
    logic [ADDR_W-1:0]         b_reg;
    logic signed [DATA_W-1:0]  b_data;
    logic                      b_ready;

    logic                      claim_valid;
    logic [ADDR_W-1:0]         claim_reg;

    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_waddr;
    logic signed [DATA_W-1:0]  rf_wdata;
    logic [2**ADDR_W-1:0]      busy;

    // Requesters, issue stage and register file side.
    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        output claim_valid, claim_reg,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata, busy
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        input  claim_valid, claim_reg,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter (ALU port A vs load port B) with pending-write scoreboard.
// Optional macro RF_ARB_FIXED_PRIO_EN: port B always wins contention (no round-robin state).
module rf_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    rf_write_arbiter_if.slave  bus
);

    localparam int NREG = 2**ADDR_W;

    logic                     contended;
    logic                     xfer;
    logic [ADDR_W-1:0]        xfer_reg;
    logic signed [DATA_W-1:0] xfer_data;
    logic [NREG-1:0]          busy_next;

`ifndef RF_ARB_FIXED_PRIO_EN
    logic rr;  // 0 favours A, 1 favours B
`endif

    assign contended = bus.a_valid && bus.b_valid;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        if (!reset) begin
            if (contended) begin
`ifdef RF_ARB_FIXED_PRIO_EN
                bus.b_ready = 1'b1;
`else
                bus.a_ready = !rr;
                bus.b_ready = rr;
`endif
            end else begin
                bus.a_ready = bus.a_valid;
                bus.b_ready = bus.b_valid;
            end
        end
    end

    assign xfer      = bus.a_ready || bus.b_ready;
    assign xfer_reg  = bus.b_ready ? bus.b_reg  : bus.a_reg;
    assign xfer_data = bus.b_ready ? bus.b_data : bus.a_data;

    // Clear for the committing write first, then set for a new claim, so set wins on collision.
    always_comb begin
        busy_next = bus.busy;
        if (bus.rf_we)
            busy_next[bus.rf_waddr] = 1'b0;
        if (bus.claim_valid)
            busy_next[bus.claim_reg] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.busy     <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
            rr           <= 1'b0;
`endif
        end else begin
            bus.rf_we <= xfer;
            if (xfer) begin
                bus.rf_waddr <= xfer_reg;
                bus.rf_wdata <= xfer_data;
            end
            bus.busy <= busy_next;
`ifndef RF_ARB_FIXED_PRIO_EN
            // After a contended grant, point at the loser: toggling does exactly that.
            if (contended)
                rr <= !rr;
`endif
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: stimulus pushes hand-computed writes, a monitor
// pops and compares each time rf_we is presented; grants and busy are checked directly.
module tb_rf_write_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    wr_t  exp_q[$];

    rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.rf_waddr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 32'(bus.rf_waddr), 32'(w.addr));
                check("wr_data", 32'($unsigned(bus.rf_wdata)), 32'(w.data));
            end
        end
    end

    initial begin
        logic exp_a;

        // Reset held with both requesters valid
        reset           = 1'b1;
        bus.a_valid     = 1'b1; bus.a_reg = 3'd1; bus.a_data = 8'sh11;
        bus.b_valid     = 1'b1; bus.b_reg = 3'd2; bus.b_data = 8'sh22;
        bus.claim_valid = 1'b0; bus.claim_reg = 3'd0;
        tick();
        tick();
        @(negedge clk);
        check("rst_a_ready", 32'(bus.a_ready), 32'd0);
        check("rst_b_ready", 32'(bus.b_ready), 32'd0);
        check("rst_rf_we",   32'(bus.rf_we),   32'd0);
        check("rst_waddr",   32'(bus.rf_waddr), 32'd0);
        check("rst_wdata",   32'($unsigned(bus.rf_wdata)), 32'd0);
        check("rst_busy",    32'(bus.busy),    32'h00);
        tick();
        reset = 1'b0;

        // Contention: A first, then alternating (fixed priority: B every cycle)
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef RF_ARB_FIXED_PRIO_EN
            exp_a = 1'b0;
`else
            exp_a = (i % 2 == 0);
`endif
            check("cont_a_ready", 32'(bus.a_ready), 32'(exp_a));
            check("cont_b_ready", 32'(bus.b_ready), 32'(!exp_a));
            if (exp_a) push(3'd1, 8'h11);
            else       push(3'd2, 8'h22);
            tick();
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        check("cont_idle_ready", 32'({bus.a_ready, bus.b_ready}), 32'd0);
        tick();
        @(negedge clk);
        check("cont_rf_we_off", 32'(bus.rf_we), 32'd0);
        check("cont_hold_addr", 32'(bus.rf_waddr), 32'd2);

        // Single requester, negative data; write to a non-busy register
        tick();
        bus.a_valid = 1'b1; bus.a_reg = 3'd3; bus.a_data = -8'sd5;
        @(negedge clk);
        check("single_a_ready", 32'(bus.a_ready), 32'd1);
        check("single_b_ready", 32'(bus.b_ready), 32'd0);
        push(3'd3, 8'hFB);
        tick();
        bus.a_valid = 1'b0;
        @(negedge clk);
        check("single_rf_we", 32'(bus.rf_we), 32'd1);
        tick();
        @(negedge clk);
        check("single_rf_we_off", 32'(bus.rf_we), 32'd0);
        check("single_hold_addr", 32'(bus.rf_waddr), 32'd3);
        check("single_hold_data", 32'($unsigned(bus.rf_wdata)), 32'hFB);
        check("single_busy", 32'(bus.busy), 32'h00);

        // Scoreboard: claim reg 5, B writes reg 5 three cycles later
        tick();
        bus.claim_valid = 1'b1; bus.claim_reg = 3'd5;
        tick();
        bus.claim_valid = 1'b0;
        @(negedge clk);
        check("sb_claim_busy", 32'(bus.busy), 32'h20);
        tick();
        tick();
        bus.b_valid = 1'b1; bus.b_reg = 3'd5; bus.b_data = 8'sh55;
        @(negedge clk);
        check("sb_b_ready", 32'(bus.b_ready), 32'd1);
        check("sb_busy_held", 32'(bus.busy), 32'h20);
        push(3'd5, 8'h55);
        tick();
        bus.b_valid = 1'b0;
        @(negedge clk);
        check("sb_busy_during_we", 32'(bus.busy), 32'h20);
        tick();
        @(negedge clk);
        check("sb_busy_cleared", 32'(bus.busy), 32'h00);

        // Set/clear collision on reg 4: set wins
        tick();
        bus.claim_valid = 1'b1; bus.claim_reg = 3'd4;
        tick();
        bus.claim_valid = 1'b0;
        bus.a_valid = 1'b1; bus.a_reg = 3'd4; bus.a_data = 8'sh44;
        push(3'd4, 8'h44);
        tick();
        bus.a_valid = 1'b0;
        bus.claim_valid = 1'b1; bus.claim_reg = 3'd4;
        tick();
        bus.claim_valid = 1'b0;
        @(negedge clk);
        check("coll_busy_set_wins", 32'(bus.busy), 32'h10);
        tick();
        bus.a_valid = 1'b1; bus.a_reg = 3'd4; bus.a_data = 8'sh45;
        push(3'd4, 8'h45);
        tick();
        bus.a_valid = 1'b0;
        tick();
        @(negedge clk);
        check("coll_busy_cleared", 32'(bus.busy), 32'h00);

        // Mid-operation reset: contended transfer at E0 sets rr, reset at E1 drops everything
        tick();
        bus.a_valid = 1'b1; bus.a_reg = 3'd1; bus.a_data = 8'sh11;
        bus.b_valid = 1'b1; bus.b_reg = 3'd2; bus.b_data = 8'sh22;
        bus.claim_valid = 1'b1; bus.claim_reg = 3'd6;
        @(negedge clk);
`ifdef RF_ARB_FIXED_PRIO_EN
        check("mid_grant_b", 32'(bus.b_ready), 32'd1);
        push(3'd2, 8'h22);
`else
        check("mid_grant_a", 32'(bus.a_ready), 32'd1);
        push(3'd1, 8'h11);
`endif
        tick();
        bus.claim_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'({bus.a_ready, bus.b_ready}), 32'd0);
        check("mid_claim_busy", 32'(bus.busy), 32'h40);
        tick();
        @(negedge clk);
        check("mid_rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'h00);
        reset = 1'b0;
        #1;
`ifdef RF_ARB_FIXED_PRIO_EN
        check("mid_after_b_ready", 32'(bus.b_ready), 32'd1);
        push(3'd2, 8'h22);
`else
        check("mid_after_rr_a", 32'(bus.a_ready), 32'd1);
        check("mid_after_rr_b", 32'(bus.b_ready), 32'd0);
        push(3'd1, 8'h11);
`endif
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        tick();
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
